// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial sequencer around one external 4-bit fast-carry adder stage: one nibble per clock, carry fed back.
// Optional build macro SERIAL_SUBTRACT_EN adds a `sub` input selecting a - b instead of a + b + cin.
module nibble_serial_adder_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES,
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c0,
  input  logic [3:0]       add_s,
  input  logic             add_c4
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [IW-1:0]    idx_q;
  logic             sub_w;
  logic             last_w;

`ifdef SERIAL_SUBTRACT_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  assign last_w = (idx_q == IW'(NIBBLES - 1));

  // Adder-facing nibble select; forced to zero whenever no sum is in flight.
  always_comb begin
    add_a  = 4'd0;
    add_b  = 4'd0;
    add_c0 = 1'b0;
    if (state_q == RUN) begin
      add_a  = 4'(a_q >> {idx_q, 2'b00});
      add_b  = 4'(b_q >> {idx_q, 2'b00});
      add_c0 = carry_q;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so b is stored inverted and the carry seeded high.
            a_q     <= a;
            b_q     <= sub_w ? ~b : b;
            carry_q <= sub_w ? 1'b1 : cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // sum_q was cleared on accept, so OR-ing the nibble in place is enough.
          sum_q   <= sum_q | (WIDTH'(add_s) << {idx_q, 2'b00});
          carry_q <= add_c4;
          if (last_w) begin
            cout_q  <= add_c4;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES=4) with a behavioural 4-bit fast-carry adder stage on add_*.
// Subtract vectors are exercised only when SERIAL_SUBTRACT_EN is defined.
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_c0, add_c4;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // Adder stage model
  assign {add_c4, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_c0);

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
    .add_s(add_s), .add_c4(add_c4)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full operation from IDLE; caller is #1 past a rising edge.
  task automatic run_op(input vec_t v);
    logic [3:0] nb;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = v.b[3:0];
    chk("busy_after_accept", busy, 1);
    chk("sum_cleared", sum, 0);
    chk("add_a_nib0", add_a, v.a[3:0]);
    chk("add_b_nib0", add_b, v.sub ? ~nb : nb);
    chk("add_c0_nib0", add_c0, v.sub ? 1'b1 : v.cin);
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      if (k < N) chk("busy_run", {busy, done}, 2'b10);
      else       chk("done_pulse", {busy, done}, 2'b01);
    end
    chk("sum", sum, v.exp_sum);
    chk("cout", cout, v.exp_cout);
    @(posedge clk); #1;
    chk("done_single", done, 0);
    chk("idle_add_a", add_a, 0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   dc0, guard, res_bad;
    logic [W:0] exp_full;
    logic [W-1:0] ra, rb;
    logic rc;

    #100_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   dc0, guard, res_bad;
    logic [W:0] exp_full;
    logic [W-1:0] ra, rb;
    logic rc;
    logic seen;

    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
    tbl.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0});
`ifdef SERIAL_SUBTRACT_EN
    tbl.push_back('{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1});
    tbl.push_back('{16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0});
    tbl.push_back('{16'h1234, 16'h1234, 1'b0, 1'b0, 16'h2468, 1'b0});
`endif

    clr_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_outputs", {busy, done, cout, add_c0}, 4'b0000);
    chk("rst_sum", sum, 0);
    chk("rst_adder_ab", {add_a, add_b}, 0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i]);

    // start held high, operands changed during RUN
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h0001;
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_done", done, 1);
    chk("hold_first_sum", {cout, sum}, {1'b0, 16'h5555});
    @(posedge clk); #1;
    chk("hold_fin_ignored", {busy, done}, 2'b00);
    @(posedge clk); #1;
    chk("hold_reaccept", busy, 1);
    start = 1'b0;
    repeat (N) begin @(posedge clk); #1; end
    chk("hold_second_done", done, 1);
    chk("hold_second_sum", {cout, sum}, {1'b1, 16'h0000});
    @(posedge clk); #1;

    // asynchronous clear mid-operation
    a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    clr_n = 1'b0;
    #1;
    chk("clr_flags", {busy, done, cout, add_c0}, 4'b0000);
    chk("clr_sum", sum, 0);
    chk("clr_adder_ab", {add_a, add_b}, 0);
    @(negedge clk);
    clr_n = 1'b1;
    dc0 = done_cnt;
    repeat (6) begin @(posedge clk); #1; end
    chk("clr_no_done", done_cnt - dc0, 0);
    v = '{16'h2468, 16'h1357, 1'b1, 1'b0, 16'h37C0, 1'b0};
    run_op(v);

    // back-to-back random operations, start held high
    dc0 = done_cnt;
    res_bad = 0;
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      a = ra; b = rb; cin = rc; sub = 1'b0;
      exp_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      seen = 1'b0;
      for (guard = 0; guard < 10; guard++) begin
        @(posedge clk); #1;
        if (busy === 1'b1) begin seen = 1'b1; break; end
      end
      chk("rand_accept", seen, 1);
      seen = 1'b0;
      for (guard = 0; guard < 10; guard++) begin
        @(posedge clk); #1;
        if (done === 1'b1) begin seen = 1'b1; break; end
      end
      chk("rand_done_seen", seen, 1);
      if (!seen) break;
      chk("rand_result", {cout, sum}, exp_full);
    end
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rand_done_count", done_cnt - dc0, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
